// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if: requester handshakes, clear control and register-file write port
interface regfile_write_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              wb_valid;
    logic              wb_ready;
    logic [ADDR_W-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              ld_valid;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_rd;
    logic [DATA_W-1:0] ld_data;
    logic              clr_req;
    logic              busy;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    modport master (
        output wb_valid, wb_rd, wb_data, ld_valid, ld_rd, ld_data, clr_req,
        input  wb_ready, ld_ready, busy, rf_we, rf_waddr, rf_wdata
    );

    modport slave (
        input  wb_valid, wb_rd, wb_data, ld_valid, ld_rd, ld_data, clr_req,
        output wb_ready, ld_ready, busy, rf_we, rf_waddr, rf_wdata
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the register-file write port between WB and LD, with hardware clear sweep
module regfile_write_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int NUM_REGS   = 32,
    parameter int MAX_WAIT   = 4,
    parameter bit CLR_ON_RST = 1'b1
) (
    input logic clk,
    input logic rst_n,
    regfile_write_arbiter_if.slave bus
);
    typedef enum logic {CLEAR, ARB} stateT;

    localparam int                WAIT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_WAIT);
    localparam stateT             RST_STATE = CLR_ON_RST ? CLEAR : ARB;

    stateT             state, stateNext;
    logic [ADDR_W-1:0] clrIdx, clrIdxNext;
    logic [WAIT_W-1:0] waitCnt, waitNext;
    logic              weQ, weNext;
    logic [ADDR_W-1:0] waddrQ, waddrNext;
    logic [DATA_W-1:0] wdataQ, wdataNext;
    logic              wbGrant, ldGrant;
    logic [ADDR_W-1:0] selRd;
    logic [DATA_W-1:0] selData;

    assign bus.wb_ready = wbGrant;
    assign bus.ld_ready = ldGrant;
    assign bus.busy     = (state == CLEAR);
    assign bus.rf_we    = weQ;
    assign bus.rf_waddr = waddrQ;
    assign bus.rf_wdata = wdataQ;

    // State, sweep index, starvation counter and the registered write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RST_STATE;
            clrIdx  <= '0;
            waitCnt <= '0;
            weQ     <= 1'b0;
            waddrQ  <= '0;
            wdataQ  <= '0;
        end else begin
            state   <= stateNext;
            clrIdx  <= clrIdxNext;
            waitCnt <= waitNext;
            weQ     <= weNext;
            waddrQ  <= waddrNext;
            wdataQ  <= wdataNext;
        end
    end

    // Sweep in CLEAR; in ARB pick a winner (forced LD, then WB, then LD) and suppress x0 writes
    always_comb begin
        stateNext  = state;
        clrIdxNext = clrIdx;
        waitNext   = waitCnt;
        wbGrant    = 1'b0;
        ldGrant    = 1'b0;
        weNext     = 1'b0;
        waddrNext  = waddrQ;
        wdataNext  = wdataQ;
        selRd      = bus.wb_rd;
        selData    = bus.wb_data;
        if (state == CLEAR) begin
            weNext     = 1'b1;
            waddrNext  = clrIdx;
            wdataNext  = '0;
            clrIdxNext = (clrIdx == LAST_IDX) ? '0 : clrIdx + 1'b1;
            stateNext  = (clrIdx == LAST_IDX) ? ARB : CLEAR;
        end else if (bus.clr_req) begin
            stateNext  = CLEAR;
            clrIdxNext = '0;
            waitNext   = '0;
        end else begin
            ldGrant  = bus.ld_valid && (waitCnt == WAIT_MAX || !bus.wb_valid);
            wbGrant  = bus.wb_valid && !ldGrant;
            waitNext = (!bus.ld_valid || ldGrant) ? '0 :
                       (waitCnt == WAIT_MAX) ? waitCnt : waitCnt + 1'b1;
            selRd    = ldGrant ? bus.ld_rd : bus.wb_rd;
            selData  = ldGrant ? bus.ld_data : bus.wb_data;
            if ((ldGrant || wbGrant) && selRd != '0) begin
                weNext    = 1'b1;
                waddrNext = selRd;
                wdataNext = selData;
            end
        end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed checks of clear sweep, arbitration, fairness, x0 and reset
module tb_regfile_write_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    regfile_write_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    regfile_write_arbiter #(
        .DATA_W(32), .ADDR_W(5), .NUM_REGS(32), .MAX_WAIT(4), .CLR_ON_RST(1'b1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.wb_valid = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
        bus.ld_valid = 1'b0; bus.ld_rd = '0; bus.ld_data = '0;
        bus.clr_req = 1'b0;
        #1;
        check("rst_we", 32'(bus.rf_we), 0);
        check("rst_waddr", 32'(bus.rf_waddr), 0);
        check("rst_wdata", bus.rf_wdata, 0);
        check("rst_busy", 32'(bus.busy), 1);
        check("rst_wb_ready", 32'(bus.wb_ready), 0);
        @(negedge clk) rst_n = 1'b1;
        #1;
        for (int i = 0; i < 32; i++) begin
            check("sweep_busy", 32'(bus.busy), 1);
            tick();
            check("sweep_we", 32'(bus.rf_we), 1);
            check("sweep_waddr", 32'(bus.rf_waddr), i);
            check("sweep_wdata", bus.rf_wdata, 0);
        end
        check("sweep_done_busy", 32'(bus.busy), 0);
        tick();
        check("idle_we", 32'(bus.rf_we), 0);

        bus.wb_valid = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = 32'hDEADBEEF;
        #1;
        check("wb_ready", 32'(bus.wb_ready), 1);
        check("wb_ld_ready", 32'(bus.ld_ready), 0);
        tick();
        check("wb_we", 32'(bus.rf_we), 1);
        check("wb_waddr", 32'(bus.rf_waddr), 5);
        check("wb_wdata", bus.rf_wdata, 32'hDEADBEEF);
        bus.wb_valid = 1'b0;
        tick();
        check("nogrant_we", 32'(bus.rf_we), 0);
        check("nogrant_hold_waddr", 32'(bus.rf_waddr), 5);
        check("nogrant_hold_wdata", bus.rf_wdata, 32'hDEADBEEF);

        bus.wb_valid = 1'b1; bus.wb_rd = 5'd9; bus.wb_data = 32'h11;
        bus.ld_valid = 1'b1; bus.ld_rd = 5'd3; bus.ld_data = 32'h7;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("fair_wb_ready", 32'(bus.wb_ready), 1);
            check("fair_ld_stall", 32'(bus.ld_ready), 0);
            tick();
            check("fair_wb_waddr", 32'(bus.rf_waddr), 9);
        end
        #1;
        check("fair_ld_ready", 32'(bus.ld_ready), 1);
        check("fair_wb_stall", 32'(bus.wb_ready), 0);
        tick();
        check("fair_ld_we", 32'(bus.rf_we), 1);
        check("fair_ld_waddr", 32'(bus.rf_waddr), 3);
        check("fair_ld_wdata", bus.rf_wdata, 32'h7);
        check("fair_wait_reset", 32'(bus.wb_ready), 1);
        tick();
        bus.wb_valid = 1'b0;

        bus.ld_valid = 1'b1; bus.ld_rd = 5'd0; bus.ld_data = 32'h55;
        #1;
        check("x0_ready", 32'(bus.ld_ready), 1);
        tick();
        check("x0_no_we", 32'(bus.rf_we), 0);
        bus.ld_valid = 1'b0;

        bus.wb_valid = 1'b1; bus.wb_rd = 5'd7; bus.wb_data = 32'hCAFE; bus.clr_req = 1'b1;
        #1;
        check("clr_wb_blocked", 32'(bus.wb_ready), 0);
        tick();
        check("clr_no_we", 32'(bus.rf_we), 0);
        check("clr_busy", 32'(bus.busy), 1);
        bus.clr_req = 1'b0;
        for (int i = 0; i < 32; i++) begin
            bus.clr_req = (i == 5);
            #1;
            check("clr_sweep_wb_ready", 32'(bus.wb_ready), 0);
            tick();
            check("clr_sweep_we", 32'(bus.rf_we), 1);
            check("clr_sweep_waddr", 32'(bus.rf_waddr), i);
        end
        bus.clr_req = 1'b0;
        check("clr_done_busy", 32'(bus.busy), 0);
        check("clr_done_wb_ready", 32'(bus.wb_ready), 1);
        tick();
        check("clr_wb_we", 32'(bus.rf_we), 1);
        check("clr_wb_waddr", 32'(bus.rf_waddr), 7);
        check("clr_wb_wdata", bus.rf_wdata, 32'hCAFE);
        bus.wb_valid = 1'b0;

        bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("mid_waddr", 32'(bus.rf_waddr), 9);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_we", 32'(bus.rf_we), 0);
        check("mid_rst_waddr", 32'(bus.rf_waddr), 0);
        check("mid_rst_busy", 32'(bus.busy), 1);
        tick();
        @(negedge clk) rst_n = 1'b1;
        tick();
        check("restart_we", 32'(bus.rf_we), 1);
        check("restart_waddr0", 32'(bus.rf_waddr), 0);
        tick();
        check("restart_waddr1", 32'(bus.rf_waddr), 1);
        for (int i = 0; i < 30; i++) tick();
        check("restart_done_busy", 32'(bus.busy), 0);

        bus.ld_valid = 1'b1; bus.ld_rd = 5'd12; bus.ld_data = 32'hABCD;
        #1;
        check("ld_alone_ready", 32'(bus.ld_ready), 1);
        tick();
        check("ld_alone_waddr", 32'(bus.rf_waddr), 12);
        check("ld_alone_wdata", bus.rf_wdata, 32'hABCD);
        bus.ld_valid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
